wide_add_seq: RTL and testbench
===============================

# wide_add_seq

Multi-word addition sequencer that sits directly upstream of the WIDTH-bit adder stage. It accepts operand word pairs least-significant word first over a valid/ready stream and adds each pair plus the running inter-word carry. It chains the carry across words, registers each sum word, and emits a result stream with word index, last flag and final carry-out. This lets fixed-width adder hardware process operands of up to MAX_WORDS*WIDTH bits.

## Interface
- WIDTH, 8, bits per operand/sum word (≥1)
- MAX_WORDS, 4, maximum words per operand (≥1, power of two not required)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word pair valid
- in_ready  out  1  block can accept input this cycle
- in_a  in  WIDTH  operand A word
- in_b  in  WIDTH  operand B word
- in_cin  in  1  carry-in; sampled only on the first word of an operand
- in_last  in  1  marks most-significant word of operand
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  sum word
- out_carry  out  1  carry out of this word; final carry-out when out_last=1
- out_last  out  1  last word of operand result
- out_idx  out  clog2(MAX_WORDS) (min 1)  word index within operand, 0 = LS word
- err  out  1  sticky: operand exceeded MAX_WORDS words

## Operation
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready (single output register, full throughput, no combinational path from in_valid to in_ready).
- State FIRST (expecting word 0) / MID (inside operand). Reset → FIRST.
- On accept, carry_used = (state==FIRST) ? in_cin : carry_q.
- {c, s} = in_a + in_b + carry_used, computed at WIDTH+1 bits. out_sum ← s, out_carry ← c, carry_q ← c.
- out_idx ← word counter. The counter increments on each accept and clears to 0 after a last word.
- Effective last = in_last || (counter == MAX_WORDS-1).
- If counter == MAX_WORDS-1 and !in_last: set err (sticky until rst) and force out_last=1. The operand terminates and the next word starts a new operand (FIRST, carry from in_cin).
- Transitions: FIRST→MID on accept with !effective last; MID→FIRST on accept with effective last; FIRST→FIRST on single-word operand. No change without an accept.
- in_cin on non-first words is ignored.
- out_* registers load only on accept. While out_valid && !out_ready, all out_* are held stable.

## Timing
- Latency: accepted pair appears on out_* with out_valid=1 on the next cycle.
- Throughput: one word per cycle when out_ready=1 continuously.
- Simultaneous transfer and accept in the same cycle: the output reloads with the new word and out_valid stays 1.
- Output transfer without accept: out_valid → 0 next cycle.
- Reset values: out_valid=0, out_sum=0, out_carry=0, out_last=0, out_idx=0, err=0, carry_q=0, counter=0, state=FIRST. in_ready=1 in the cycle after reset deasserts.
- rst mid-operand: the partial operand is discarded with no output of pending words. The next accepted word is treated as word 0.
- MAX_WORDS=1: every word is effectively last. err is set when in_last=0.

## Test plan
- Single word, WIDTH=8: a=0xFF, b=0x01, cin=0, last=1 → next cycle out_sum=0x00, out_carry=1, out_last=1, out_idx=0; err=0.
- Three-word 0x00FFFF+0x000001, LS first, cin=0: pairs (FF,01), (FF,00), (00,00,last) → sums 0x00, 0x00, 0x01 with idx 0,1,2; out_carry 1,1,0; out_last only on idx 2.
- cin ignored mid-operand: operand (0x10,0x20,cin=1), (0x01,0x01,cin=1,last) → sums 0x31, 0x02; final carry 0.
- Backpressure: stream 4 words with out_ready low for 3 cycles after the first → in_ready=0 and out_* stable during the stall; all 4 results are delivered in order with no duplication or loss.
- Overflow, MAX_WORDS=4: 5 words, none with last → word idx 3 emitted with out_last=1 and err=1. The 5th word is emitted with idx 0 using its own in_cin. err stays 1 until rst.
- Reset mid-operand: after word 0 (0xFF+0x01, carry 1), assert rst one cycle, then send (0x00,0x00,cin=0,last) → out_sum=0x00, out_carry=0, out_idx=0 (no carry leak).

Source files
------------

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-word addition sequencer.
// Takes operand word pairs LS word first, adds each pair with the carry chained
// from the previous word, and emits registered sum words tagged with word index,
// last flag and carry-out. Operands longer than MAX_WORDS are cut off at
// MAX_WORDS words, and err is raised and held until reset.
module wide_add_seq #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 4,
    localparam int IDXW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_last,
    output logic [IDXW-1:0]  out_idx,
    output logic             err
);

    typedef enum logic {
        FIRST = 1'b0,  // waiting for word 0 of an operand
        MID   = 1'b1   // inside an operand, carry chained from carry_q
    } state_t;

    state_t          state;
    logic            carry_q;
    logic [IDXW-1:0] counter;

    logic            accept;
    logic            carry_used;
    logic            at_max;
    logic            eff_last;
    logic [WIDTH:0]  word_sum;

    // The single output register frees up when it is empty or being drained this
    // cycle. This makes in_ready independent of in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Word 0 takes its carry from in_cin. Later words take the chained carry.
    assign carry_used = (state == FIRST) ? in_cin : carry_q;

    // The operand is forced to end when it reaches the last word slot.
    assign at_max   = (counter == IDXW'(MAX_WORDS - 1));
    assign eff_last = in_last || at_max;

    // The add is done at WIDTH+1 bits so that the top bit is the carry-out of this word.
    assign word_sum = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry_used};

    // Sequencer state, carry chain, word counter, output register and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking (<=) so that every register
            // samples pre-edge values, independent of statement order.
            state     <= FIRST;
            carry_q   <= 1'b0;
            counter   <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_sum   <= word_sum[WIDTH-1:0];
                out_carry <= word_sum[WIDTH];
                out_last  <= eff_last;
                out_idx   <= counter;
                carry_q   <= word_sum[WIDTH];
                if (at_max && !in_last) begin
                    err <= 1'b1;
                end
                if (eff_last) begin
                    counter <= '0;
                    state   <= FIRST;
                end else begin
                    counter <= counter + IDXW'(1);
                    state   <= MID;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: randomized, self-checking bench for wide_add_seq.
// The reference model works on whole operands as wide integers. Each expected
// sum word is a slice of the running operand total, and each carry is the bit
// just above that slice.
module tb_wide_add_seq;

    localparam int W  = 8;
    localparam int MW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_carry;
    logic          out_last;
    logic [IW-1:0] out_idx;
    logic          err;

    always #5 clk = ~clk;

    wide_add_seq #(.WIDTH(W), .MAX_WORDS(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .err       (err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         last;
    } word_t;

    typedef struct {
        logic [W-1:0]  sum;
        logic          carry;
        logic          last;
        logic [IW-1:0] idx;
    } res_t;

    word_t stim_q[$];
    res_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model state: the operand collected so far, held as wide integers
    longint seg_a, seg_b;
    longint seg_cin;
    int     seg_k;
    logic   m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        seg_a   = 0;
        seg_b   = 0;
        seg_cin = 0;
        seg_k   = 0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_push(input word_t w);
        longint total;
        res_t   r;
        logic   eff;
        if (seg_k == 0) seg_cin = longint'(w.cin);
        seg_a = seg_a | (longint'(w.a) << (W * seg_k));
        seg_b = seg_b | (longint'(w.b) << (W * seg_k));
        total = seg_a + seg_b + seg_cin;
        r.sum   = W'(total >> (W * seg_k));
        r.carry = 1'((total >> (W * (seg_k + 1))) & 1);
        r.idx   = IW'(seg_k);
        eff     = w.last || (seg_k == MW - 1);
        r.last  = eff;
        if (seg_k == MW - 1 && !w.last) m_err = 1'b1;
        if (eff) begin
            seg_k = 0;
            seg_a = 0;
            seg_b = 0;
        end else begin
            seg_k++;
        end
        exp_q.push_back(r);
    endtask

    task automatic push_word(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic last);
        word_t w;
        w.a = a; w.b = b; w.cin = cin; w.last = last;
        stim_q.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drives stim_q with random valid gaps and random backpressure, and forces
    // out_ready low for the cycle window [stall_lo, stall_hi]. Every output transfer
    // is compared with the model, in order.
    task automatic run_stream(input int p_valid, input int p_ready,
                              input int stall_lo, input int stall_hi);
        int   si  = 0;
        int   cyc = 0;
        res_t r;
        logic         held = 1'b0;
        logic [W-1:0] held_sum = '0;
        logic [IW-1:0] held_idx = '0;
        foreach (stim_q[i]) model_push(stim_q[i]);
        while ((si < stim_q.size() || exp_q.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (si < stim_q.size() && $urandom_range(99) < p_valid) begin
                in_valid = 1'b1;
                in_a     = stim_q[si].a;
                in_b     = stim_q[si].b;
                in_cin   = stim_q[si].cin;
                in_last  = stim_q[si].last;
            end else begin
                in_valid = 1'b0;
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_cin   = 1'($urandom);
                in_last  = 1'($urandom);
            end
            if (cyc >= stall_lo && cyc <= stall_hi) out_ready = 1'b0;
            else out_ready = ($urandom_range(99) < p_ready);
            #1;
            if (held) begin
                check("hold_sum", out_sum, held_sum);
                check("hold_idx", out_idx, held_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("sum", out_sum, r.sum);
                    check("carry", out_carry, r.carry);
                    check("last", out_last, r.last);
                    check("idx", out_idx, r.idx);
                end
            end
            held = out_valid && !out_ready;
            held_sum = out_sum;
            held_idx = out_idx;
            if (held) check("in_ready_stall", in_ready, 0);
            if (in_valid && in_ready) si++;
        end
        if (cyc >= 5000) check("stream_timeout", cyc, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stim_q.delete();
        exp_q.delete();
    endtask

    task automatic random_stream(input int n_ops);
        int len;
        for (int op = 0; op < n_ops; op++) begin
            len = ($urandom_range(9) == 0) ? MW + 1 : $urandom_range(MW, 1);
            for (int k = 0; k < len; k++) begin
                push_word(($urandom_range(3) == 0) ? W'(8'hFF) : W'($urandom),
                          ($urandom_range(3) == 0) ? W'(8'hFF) : W'($urandom),
                          1'($urandom),
                          (len <= MW) && (k == len - 1));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        do_reset();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);

        // Single word with a carry out
        push_word(8'hFF, 8'h01, 1'b0, 1'b1);
        run_stream(100, 100, 0, -1);
        check("single_err", err, 0);

        // Three-word carry chain: 0x00FFFF + 0x000001
        push_word(8'hFF, 8'h01, 1'b0, 1'b0);
        push_word(8'hFF, 8'h00, 1'b0, 1'b0);
        push_word(8'h00, 8'h00, 1'b0, 1'b1);
        run_stream(100, 100, 0, -1);

        // in_cin on a non-first word must be ignored
        push_word(8'h10, 8'h20, 1'b1, 1'b0);
        push_word(8'h01, 8'h01, 1'b1, 1'b1);
        run_stream(100, 100, 0, -1);

        // Backpressure: 4 words, out_ready held low for 3 cycles after the first
        push_word(8'h12, 8'h34, 1'b0, 1'b0);
        push_word(8'hF0, 8'h0F, 1'b0, 1'b0);
        push_word(8'h80, 8'h80, 1'b1, 1'b0);
        push_word(8'h7F, 8'h00, 1'b0, 1'b1);
        run_stream(100, 100, 2, 4);

        // Reset mid-operand must not leak the carry into the next operand
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01; in_cin = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid_w0_valid", out_valid, 1);
        check("mid_w0_sum", out_sum, 8'h00);
        check("mid_w0_carry", out_carry, 1);
        check("mid_w0_idx", out_idx, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst_valid", out_valid, 0);
        push_word(8'h00, 8'h00, 1'b0, 1'b1);
        run_stream(100, 100, 0, -1);

        // Overflow: five words, none marked last; the fifth restarts with its own cin
        do_reset();
        push_word(8'hFF, 8'hFF, 1'b0, 1'b0);
        push_word(8'h01, 8'h02, 1'b0, 1'b0);
        push_word(8'hFF, 8'h00, 1'b1, 1'b0);
        push_word(8'hFF, 8'h01, 1'b0, 1'b0);
        push_word(8'h00, 8'h00, 1'b1, 1'b0);
        run_stream(100, 100, 0, -1);
        check("ovf_err", err, m_err);
        check("ovf_err_set", err, 1);

        // Continue randomly from the open operand; err must stay sticky
        random_stream(40);
        run_stream(70, 60, 0, -1);
        check("err_sticky", err, 1);

        // Fresh random traffic with heavy backpressure
        do_reset();
        #1;
        check("err_cleared", err, 0);
        random_stream(80);
        run_stream(70, 50, 0, -1);
        check("rand_err", err, m_err);

        // Full-throughput random traffic
        do_reset();
        random_stream(60);
        run_stream(100, 100, 0, -1);
        check("rand2_err", err, m_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
